// File: rtl/nfifo_rd_stream.sv
// nfifo_rd_stream: pops a synchronous FIFO and re-times its read data into a valid/ready stream.
// Define NFIFO_RD_STATS_EN to add saturating handshake and stall counters.
module nfifo_rd_stream #(
    parameter int width  = 32,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    input  logic [width-1:0] fifo_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [width-1:0] m_data_o,
    input  logic             flush_i,
`ifdef NFIFO_RD_STATS_EN
    output logic [31:0]      stat_words_o,
    output logic [31:0]      stat_stall_o,
`endif
    output logic             busy_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    if (RD_LAT < 1) begin : g_bad_lat
        $error("nfifo_rd_stream: RD_LAT must be >= 1");
    end
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("nfifo_rd_stream: DEPTH must be a power of 2");
    end

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [RD_LAT-1:0] sh_q, sh_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [width-1:0]  buf_q [DEPTH];
    logic [width-1:0]  buf_d [DEPTH];

    logic run;
    logic credit_ok;
    logic pop_acc;
    logic hs;
    logic drop;
    logic cap;
    int   inflight;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    // Credits cover both buffered and in-flight words, so the buffer cannot overflow.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (sh_q[i]) begin
                inflight++;
            end
        end
        run       = (state_q == RUN);
        credit_ok = (int'(count_q) + inflight) < DEPTH;
        fifo_rd_o = run & ~rst_i & ~fifo_empty_i & credit_ok;
        pop_acc   = fifo_rd_o & ~fifo_empty_i;
        m_valid_o = (count_q != '0);
        m_data_o  = buf_q[rd_ptr_q];
        busy_o    = (state_q == FLUSH);
        hs        = m_valid_o & m_ready_i;
        drop      = ~run | flush_i;
        cap       = sh_q[RD_LAT-1] & ~drop;
    end

    always_comb begin
        sh_d[0] = pop_acc;
        for (int i = 1; i < RD_LAT; i++) begin
            sh_d[i] = sh_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (inflight == 0 && !flush_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Entering or holding FLUSH empties the buffer; returning words are dropped.
    always_comb begin
        buf_d    = buf_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (drop) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (cap) begin
                buf_d[wr_ptr_q] = fifo_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (hs) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({cap, hs})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            sh_q     <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            buf_q    <= buf_d;
        end
    end

`ifdef NFIFO_RD_STATS_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_words_d = stat_words_q;
        stat_stall_d = stat_stall_q;
        if (hs && stat_words_q != '1) begin
            stat_words_d = stat_words_q + 32'd1;
        end
        if (m_valid_o && !m_ready_i && stat_stall_q != '1) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_words_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_words_o = stat_words_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_nfifo_rd_stream.sv
// Bench for nfifo_rd_stream: queue-level FIFO and stream model, directed scenarios
// followed by randomized traffic with flushes and resets.
module tb_nfifo_rd_stream;

    localparam int W      = 32;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd;
    logic [W-1:0] fifo_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [W-1:0] m_data;
    logic         flush = 1'b0;
    logic         busy;
`ifdef NFIFO_RD_STATS_EN
    logic [31:0]  stat_words;
    logic [31:0]  stat_stall;
`endif

    always #5 clk = ~clk;

    nfifo_rd_stream #(
        .width (W),
        .RD_LAT(RD_LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .fifo_empty_i(fifo_empty),
        .fifo_rd_o   (fifo_rd),
        .fifo_data_i (fifo_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .flush_i     (flush),
`ifdef NFIFO_RD_STATS_EN
        .stat_words_o(stat_words),
        .stat_stall_o(stat_stall),
`endif
        .busy_o      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit nx_rst = 1'b1;
    bit nx_ready = 1'b1;
    bit nx_flush = 1'b0;
    bit nx_force_empty = 1'b0;

    logic [W-1:0] fifo_mem[$];
    logic [W-1:0] phys_word[$];
    int           phys_due[$];

    logic [W-1:0] m_buf[$];
    logic [W-1:0] m_pw[$];
    int           m_pd[$];
    bit           m_run = 1'b1;
    logic [31:0]  m_words = '0;
    logic [31:0]  m_stall = '0;

    logic [W-1:0] seen[$];
    int           seen_cyc[$];
    int           pops = 0;
    int           first_pop_cyc = -1;
    int           first_valid_cyc = -1;
    int           busy_cycles;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        bit           acc;
        bit           hs;
        bit           arrive;
        bit           exp_rd;
        bit           exp_valid;
        bit           idle;
        logic [W-1:0] w;
        logic [W-1:0] aw;
        w  = '0;
        aw = '0;
        @(negedge clk);
        cyc++;
        if (phys_due.size() != 0 && phys_due[0] == cyc) begin
            fifo_data = phys_word.pop_front();
            void'(phys_due.pop_front());
        end else begin
            fifo_data = $urandom;
        end
        rst        = nx_rst;
        m_ready    = nx_ready;
        flush      = nx_flush;
        fifo_empty = (fifo_mem.size() == 0) || nx_force_empty;
        #1;
        exp_rd    = !rst && m_run && !fifo_empty &&
                    (m_buf.size() + m_pd.size() < DEPTH);
        exp_valid = (m_buf.size() != 0);
        chk1("fifo_rd", fifo_rd, exp_rd);
        chk1("m_valid", m_valid, exp_valid);
        chk1("busy", busy, !m_run);
        if (exp_valid) begin
            chkw("m_data", m_data, m_buf[0]);
        end
        chk1("count_bound", dut.count_q <= DEPTH, 1'b1);
`ifdef NFIFO_RD_STATS_EN
        chkw("stat_words", stat_words, m_words);
        chkw("stat_stall", stat_stall, m_stall);
`endif
        acc = fifo_rd && !fifo_empty;
        hs  = exp_valid && m_ready;
        if (m_valid === 1'b1 && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
        end
        if (m_valid === 1'b1 && m_ready) begin
            seen.push_back(m_data);
            seen_cyc.push_back(cyc);
        end
        if (acc) begin
            w = fifo_mem.pop_front();
            phys_word.push_back(w);
            phys_due.push_back(cyc + RD_LAT);
            pops++;
            if (first_pop_cyc < 0) begin
                first_pop_cyc = cyc;
            end
        end
        if (rst) begin
            m_buf.delete();
            m_pw.delete();
            m_pd.delete();
            m_run   = 1'b1;
            m_words = '0;
            m_stall = '0;
        end else begin
            if (hs && m_words != 32'hFFFF_FFFF) begin
                m_words++;
            end
            if (exp_valid && !m_ready && m_stall != 32'hFFFF_FFFF) begin
                m_stall++;
            end
            idle   = (m_pd.size() == 0);
            arrive = (m_pd.size() != 0) && (m_pd[0] == cyc);
            if (arrive) begin
                aw = m_pw.pop_front();
                void'(m_pd.pop_front());
            end
            if (hs) begin
                void'(m_buf.pop_front());
            end
            if (!m_run || flush) begin
                m_buf.delete();
            end else if (arrive) begin
                m_buf.push_back(aw);
            end
            if (acc) begin
                m_pw.push_back(w);
                m_pd.push_back(cyc + RD_LAT);
            end
            if (m_run && flush) begin
                m_run = 1'b0;
            end else if (!m_run && idle && !flush) begin
                m_run = 1'b1;
            end
        end
    endtask

    task automatic run_until_seen(input string name, input int n, input int budget);
        for (int k = 0; k < budget && seen.size() < n; k++) begin
            tick();
        end
        chkw(name, seen.size(), n);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            fifo_mem.push_back(32'hA + i);
        end
        nx_rst = 1'b1;
        repeat (3) tick();
        chk1("reset_rd", fifo_rd, 1'b0);
        chk1("reset_valid", m_valid, 1'b0);
        chkw("reset_data", m_data, 32'h0);
        chk1("reset_busy", busy, 1'b0);

        nx_rst = 1'b0;
        first_pop_cyc   = -1;
        first_valid_cyc = -1;
        seen.delete();
        seen_cyc.delete();
        tick();
        chk1("first_pop_after_reset", fifo_rd, 1'b1);
        run_until_seen("abcd_count", 4, 20);
        chkw("abcd_latency", first_valid_cyc - first_pop_cyc, 2);
        for (int i = 0; i < seen.size(); i++) begin
            chkw("abcd_word", seen[i], 32'hA + i);
        end
        if (seen.size() == 4) begin
            chkw("abcd_rate", seen_cyc[3] - seen_cyc[0], 3);
        end

        seen.delete();
        pops     = 0;
        nx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fifo_mem.push_back(32'h100 + i);
        end
        repeat (10) tick();
        chkw("stall_pops", pops, 4);
        chk1("stall_rd_off", fifo_rd, 1'b0);
        chkw("stall_hold", m_data, 32'h100);
        nx_ready = 1'b1;
        run_until_seen("stall_count", 10, 40);
        for (int i = 0; i < seen.size(); i++) begin
            chkw("stall_order", seen[i], 32'h100 + i);
        end

        seen.delete();
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            fifo_mem.push_back(32'h300 + i);
        end
        for (int k = 0; k < 60 && seen.size() < 8; k++) begin
            nx_force_empty = k[0];
            tick();
        end
        nx_force_empty = 1'b0;
        chkw("toggle_pops", pops, 8);
        chkw("toggle_count", seen.size(), 8);
        for (int i = 0; i < seen.size(); i++) begin
            chkw("toggle_order", seen[i], 32'h300 + i);
        end

        seen.delete();
        nx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fifo_mem.push_back(32'h200 + i);
        end
        for (int k = 0; k < 20 && !(m_buf.size() == 3 && m_pd.size() == 1); k++) begin
            tick();
        end
        chk1("flush_setup", m_buf.size() == 3 && m_pd.size() == 1, 1'b1);
        nx_flush = 1'b1;
        tick();
        nx_flush = 1'b0;
        nx_ready = 1'b1;
        fifo_mem.push_back(32'h55);
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy) begin
                busy_cycles++;
            end else begin
                break;
            end
        end
        chkw("flush_busy_cycles", busy_cycles, 1);
        run_until_seen("flush_after_count", 1, 20);
        if (seen.size() != 0) begin
            chkw("flush_first_word", seen[0], 32'h55);
        end

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 1) == 0 && fifo_mem.size() < 20) begin
                fifo_mem.push_back($urandom);
            end
            nx_ready       = ($urandom_range(0, 3) != 0);
            nx_force_empty = ($urandom_range(0, 7) == 0);
            nx_flush       = ($urandom_range(0, 99) == 0);
            nx_rst         = ($urandom_range(0, 499) == 0);
            tick();
        end
        nx_ready       = 1'b1;
        nx_force_empty = 1'b0;
        nx_flush       = 1'b0;
        nx_rst         = 1'b0;

`ifdef NFIFO_RD_STATS_EN
        fifo_mem.delete();
        nx_rst = 1'b1;
        tick();
        nx_rst   = 1'b0;
        nx_ready = 1'b0;
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            fifo_mem.push_back(32'h400 + i);
        end
        for (int k = 0; k < 20 && m_buf.size() == 0; k++) begin
            tick();
        end
        repeat (3) tick();
        nx_ready = 1'b1;
        run_until_seen("stats_count", 5, 30);
        tick();
        chkw("stats_words_lit", stat_words, 32'd5);
        chkw("stats_stall_lit", stat_stall, 32'd3);
`endif

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
